rv_iommu_ddtp_quiesce_ctrl: RTL

Sequences the quiesce handshake a DDTP write needs before the new device-directory root takes effect. It sits between the MMIO register block and the page-walk front end. When the MMIO block raises its stall request, this block:
- stops granting new walks,
- drains in-flight walks,
- triggers an IOATC flush,
- returns a one-cycle idle indication so the MMIO block can commit its shadow DDTP state.

It also keeps the outstanding-walk count and flags underflow errors.

---
 rtl/rv_iommu_ddtp_quiesce_ctrl.sv | 89 ++++++++
 1 files changed

// File: rtl/rv_iommu_ddtp_quiesce_ctrl.sv
// DDTP quiesce sequencer: blocks new walks, drains in-flight walks, flushes the IOATC, then pulses idle.
// Stall-to-idle is 3 cycles minimum; req_ready_o is the only combinational output.
module rv_iommu_ddtp_quiesce_ctrl #(
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall_req_i,
   output logic          pgwk_idle_o,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          walk_done_i,
   output logic          flush_req_o,
   input  logic          flush_ack_i,
   output logic [CW-1:0] outstanding_o,
   output logic          quiesce_busy_o,
   output logic          err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_FLUSH,
      S_COMMIT,
      S_WAIT_CLR
   } state_t;

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          err;
   logic          err_nxt;
   logic          accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err   <= err_nxt;
      end
   end

   // Once DRAIN is entered the sequence runs to COMMIT regardless of stall_req_i.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (stall_req_i) state_nxt = S_DRAIN;
         S_DRAIN:    if (cnt == '0) state_nxt = S_FLUSH;
         S_FLUSH:    if (flush_ack_i) state_nxt = S_COMMIT;
         S_COMMIT:   state_nxt = S_WAIT_CLR;
         S_WAIT_CLR: if (!stall_req_i) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   assign req_ready_o = (state == S_IDLE) && !stall_req_i && (cnt < MAX_CNT);
   assign accept      = req_valid_i && req_ready_o;

   // A completion with nothing outstanding is an underflow: hold at zero and latch the error.
   always_comb begin
      cnt_nxt = cnt;
      err_nxt = err;
      if (accept && !walk_done_i) begin
         cnt_nxt = cnt + ONE;
      end else if (!accept && walk_done_i) begin
         if (cnt == '0) begin
            err_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt - ONE;
         end
      end
   end

   assign flush_req_o    = (state == S_FLUSH);
   assign pgwk_idle_o    = (state == S_COMMIT);
   assign quiesce_busy_o = (state != S_IDLE);
   assign outstanding_o  = cnt;
   assign err_o          = err;

endmodule
